// File: rtl/fpu_issuer.sv
// fpu_issuer: issues one op at a time to a fixed-latency FPU and
// returns the captured result and its class over a valid/ready channel.
module fpu_issuer #(
   parameter int LAT_ADD  = 3,
   parameter int LAT_SQRT = 12,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_op,
   output logic        rsp_nan,
   output logic        rsp_inf,
   output logic        rsp_zero,
   output logic        rsp_dz,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_s,
   input  logic [31:0] fpu_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [7:0] L_ADD  = 8'(LAT_ADD);
   localparam logic [7:0] L_SQRT = 8'(LAT_SQRT);
   localparam logic [7:0] L_MUL  = 8'(LAT_MUL);
   localparam logic [7:0] L_DIV  = 8'(LAT_DIV);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [7:0] lat_sel;
   logic       acc, cap;
   logic [7:0] o_exp;
   logic       o_man_z;

   assign req_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == DONE);
   assign acc       = req_valid && req_ready;
   assign cap       = (state == WAIT) && (cnt == 8'd1);
   assign o_exp     = fpu_o[30:23];
   assign o_man_z   = (fpu_o[22:0] == 23'd0);

   always_comb begin
      case (req_op)
         2'b00:   lat_sel = L_ADD;
         2'b01:   lat_sel = L_SQRT;
         2'b10:   lat_sel = L_MUL;
         default: lat_sel = L_DIV;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (acc) begin
               state_nx = WAIT;
               cnt_nx   = lat_sel;
            end
         end
         WAIT: begin
            if (cnt == 8'd1) state_nx = DONE;
            else             cnt_nx   = cnt - 8'd1;
         end
         DONE: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Reset discards any in-flight op; no response is produced for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         fpu_a    <= 32'd0;
         fpu_b    <= 32'd0;
         fpu_s    <= 2'd0;
         rsp_op   <= 2'd0;
         rsp_dz   <= 1'b0;
         rsp_data <= 32'd0;
         rsp_nan  <= 1'b0;
         rsp_inf  <= 1'b0;
         rsp_zero <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (acc) begin
            fpu_a  <= req_a;
            fpu_b  <= req_b;
            fpu_s  <= req_op;
            rsp_op <= req_op;
            rsp_dz <= (req_op == 2'b11) && (req_b[30:0] == 31'd0);
         end
         if (cap) begin
            rsp_data <= fpu_o;
            rsp_nan  <= (o_exp == 8'hFF) && !o_man_z;
            rsp_inf  <= (o_exp == 8'hFF) && o_man_z;
            rsp_zero <= (o_exp == 8'h00) && o_man_z;
         end
      end
   end

endmodule
